// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and run-control state encoding for the fetch stage.
package ifu_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Control, program-load and IF/ID signals of the fetch stage.
interface instruction_fetch_unit_if #(
   parameter int unsigned NB_DATA = 32,
   parameter int unsigned NB_PC   = 10
) ();

   logic               i_start;
   logic               i_stall;
   logic               i_branch_taken;
   logic [NB_PC-1:0]   i_branch_target;
   logic               i_inst_wr_enb;
   logic [NB_PC-1:0]   i_inst_wr_addr;
   logic [NB_DATA-1:0] i_inst_wr_data;
   logic [NB_DATA-1:0] o_instruction_ltchd;
   logic [NB_PC-1:0]   o_pc_ltchd;
   logic               o_running;
   logic               o_halted;

   // Driver side: control, redirect and program load
   modport master (
      output i_start, i_stall, i_branch_taken, i_branch_target,
             i_inst_wr_enb, i_inst_wr_addr, i_inst_wr_data,
      input  o_instruction_ltchd, o_pc_ltchd, o_running, o_halted
   );

   // Fetch unit side
   modport slave (
      input  i_start, i_stall, i_branch_taken, i_branch_target,
             i_inst_wr_enb, i_inst_wr_addr, i_inst_wr_data,
      output o_instruction_ltchd, o_pc_ltchd, o_running, o_halted
   );

endinterface

// File: rtl/instruction_fetch_unit_instruction_memory.sv
// Instruction store: asynchronous read, synchronous write, no reset of contents.
module instruction_memory #(
   parameter int unsigned NB_DATA = 32,
   parameter int unsigned NB_PC   = 10
) (
   input  logic               clk_i,
   input  logic               we_i,
   input  logic [NB_PC-1:0]   waddr_i,
   input  logic [NB_DATA-1:0] wdata_i,
   input  logic [NB_PC-1:0]   raddr_i,
   output logic [NB_DATA-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** NB_PC;

   logic [NB_DATA-1:0] mem_q [DEPTH];

   // Program-load write port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: run-control FSM, program counter and IF/ID pipeline latch.
module instruction_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned        NB_DATA    = 32,
   parameter int unsigned        NB_PC      = 10,
   parameter logic [NB_DATA-1:0] HALT_INSTR = ifu_pkg::HALT_INSTR,
   parameter logic [NB_DATA-1:0] NOP_INSTR  = ifu_pkg::NOP_INSTR
) (
   input  logic                     i_clock,
   input  logic                     i_reset_n,
   instruction_fetch_unit_if.slave  bus
);

   ifu_state_e         state_q;
   logic [NB_PC-1:0]   pc_q;
   logic [NB_PC-1:0]   pc_ltchd_q;
   logic [NB_DATA-1:0] instr_q;
   logic               running_q;
   logic               halted_q;

   logic [NB_DATA-1:0] fetch_word;
   logic [NB_PC-1:0]   pc_inc;
   logic               mem_we;

   // Loading is only legal while idle so a running program cannot be modified
   assign mem_we = bus.i_inst_wr_enb && (state_q == IDLE);
   assign pc_inc = pc_q + NB_PC'(1);

   instruction_memory #(
      .NB_DATA (NB_DATA),
      .NB_PC   (NB_PC)
   ) u_imem (
      .clk_i   (i_clock),
      .we_i    (mem_we),
      .waddr_i (bus.i_inst_wr_addr),
      .wdata_i (bus.i_inst_wr_data),
      .raddr_i (pc_q),
      .rdata_o (fetch_word)
   );

   // Run-control FSM with PC, IF/ID latch and registered status decodes
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         pc_ltchd_q <= '0;
         instr_q    <= NOP_INSTR;
         running_q  <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               instr_q <= NOP_INSTR;
               if (bus.i_start) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            RUN: begin
               if (bus.i_branch_taken) begin
                  // Redirect wins over stall and HALT; one bubble penalty
                  pc_q       <= bus.i_branch_target;
                  pc_ltchd_q <= bus.i_branch_target;
                  instr_q    <= NOP_INSTR;
               end else if (bus.i_stall) begin
                  // Hold PC and latch
               end else if (fetch_word == HALT_INSTR) begin
                  // HALT never enters decode; PC parks on the HALT word
                  instr_q   <= NOP_INSTR;
                  state_q   <= HALTED;
                  running_q <= 1'b0;
                  halted_q  <= 1'b1;
               end else begin
                  instr_q    <= fetch_word;
                  pc_ltchd_q <= pc_inc;
                  pc_q       <= pc_inc;
               end
            end
            HALTED: begin
               instr_q <= NOP_INSTR;
            end
            default: begin
               state_q   <= IDLE;
               instr_q   <= NOP_INSTR;
               running_q <= 1'b0;
               halted_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_instruction_ltchd = instr_q;
   assign bus.o_pc_ltchd          = pc_ltchd_q;
   assign bus.o_running           = running_q;
   assign bus.o_halted            = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for the fetch stage.
module tb_instruction_fetch_unit;

   localparam int unsigned NB_DATA = 32;
   localparam int unsigned NB_PC   = 10;

   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [31:0] WA   = 32'h1111_0001;
   localparam logic [31:0] WB   = 32'h2222_0002;
   localparam logic [31:0] WC   = 32'h3333_0003;
   localparam logic [31:0] WD   = 32'h4444_0004;
   localparam logic [31:0] WX   = 32'hABCD_0000;
   localparam logic [31:0] WY   = 32'h1234_5678;
   localparam logic [31:0] WZ   = 32'hDEAD_BEEF;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   instruction_fetch_unit_if #(.NB_DATA(NB_DATA), .NB_PC(NB_PC)) bus ();

   instruction_fetch_unit #(
      .NB_DATA (NB_DATA),
      .NB_PC   (NB_PC)
   ) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic load(input logic [NB_PC-1:0] addr, input logic [31:0] data);
      bus.i_inst_wr_enb  = 1'b1;
      bus.i_inst_wr_addr = addr;
      bus.i_inst_wr_data = data;
      tick();
      bus.i_inst_wr_enb  = 1'b0;
   endtask

   task automatic start_run();
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd, bus.o_running, bus.o_halted}
          !== {NOP, 10'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_async: got %h/%0d run=%b halt=%b want NOP/0/0/0",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, bus.o_running, bus.o_halted);
      end
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      n_cmp++;
      if (bus.o_running !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold: running=%b want 0", bus.o_running);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_load_run();
      logic [31:0] ei [4] = '{WA, WB, WC, WD};
      do_reset();
      load(10'd0, WA);
      load(10'd1, WB);
      load(10'd2, WC);
      load(10'd3, WD);
      load(10'd4, WA);
      load(10'd5, WB);
      start_run();
      n_cmp++;
      if ({bus.o_running, bus.o_instruction_ltchd} !== {1'b1, NOP}) begin
         n_err++;
         $display("FAIL run_entry: run=%b instr=%h want run=1 instr=%h",
                  bus.o_running, bus.o_instruction_ltchd, NOP);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if ({bus.o_instruction_ltchd, bus.o_pc_ltchd} !== {ei[i], 10'(i + 1)}) begin
            n_err++;
            $display("FAIL fetch_seq[%0d]: got %h/%0d want %h/%0d", i,
                     bus.o_instruction_ltchd, bus.o_pc_ltchd, ei[i], i + 1);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      start_run();
      tick();
      tick();
      bus.i_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({bus.o_instruction_ltchd, bus.o_pc_ltchd} !== {WB, 10'd2}) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got %h/%0d want %h/2", i,
                     bus.o_instruction_ltchd, bus.o_pc_ltchd, WB);
         end
      end
      bus.i_stall = 1'b0;
      tick();
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd} !== {WC, 10'd3}) begin
         n_err++;
         $display("FAIL stall_resume: got %h/%0d want %h/3",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, WC);
      end
   endtask

   task automatic test_branch();
      do_reset();
      start_run();
      tick();
      bus.i_branch_taken  = 1'b1;
      bus.i_branch_target = 10'd3;
      tick();
      bus.i_branch_taken  = 1'b0;
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd} !== {NOP, 10'd3}) begin
         n_err++;
         $display("FAIL branch_bubble: got %h/%0d want %h/3",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, NOP);
      end
      tick();
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd} !== {WD, 10'd4}) begin
         n_err++;
         $display("FAIL branch_target: got %h/%0d want %h/4",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, WD);
      end
   endtask

   task automatic test_halt();
      do_reset();
      load(10'd2, HALT);
      start_run();
      tick();
      tick();
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd} !== {WB, 10'd2}) begin
         n_err++;
         $display("FAIL halt_pre: got %h/%0d want %h/2",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, WB);
      end
      tick();
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd, bus.o_running, bus.o_halted}
          !== {NOP, 10'd2, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL halt_enter: got %h/%0d run=%b halt=%b want NOP/2/0/1",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, bus.o_running, bus.o_halted);
      end
      // Start and program writes must be ignored while halted
      bus.i_start        = 1'b1;
      bus.i_inst_wr_enb  = 1'b1;
      bus.i_inst_wr_addr = 10'd0;
      bus.i_inst_wr_data = WZ;
      tick();
      tick();
      bus.i_start       = 1'b0;
      bus.i_inst_wr_enb = 1'b0;
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd, bus.o_running, bus.o_halted}
          !== {NOP, 10'd2, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL halt_sticky: got %h/%0d run=%b halt=%b want NOP/2/0/1",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, bus.o_running, bus.o_halted);
      end
      do_reset();
      load(10'd2, WC);
      start_run();
      tick();
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd} !== {WA, 10'd1}) begin
         n_err++;
         $display("FAIL halt_write_dropped: got %h/%0d want %h/1",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, WA);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      start_run();
      tick();
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd, bus.o_running, bus.o_halted}
          !== {NOP, 10'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL midrun_reset: got %h/%0d run=%b halt=%b want NOP/0/0/0",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, bus.o_running, bus.o_halted);
      end
      #1;
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if ({bus.o_running, bus.o_instruction_ltchd} !== {1'b0, NOP}) begin
         n_err++;
         $display("FAIL idle_after_reset: run=%b instr=%h want 0/%h",
                  bus.o_running, bus.o_instruction_ltchd, NOP);
      end
      start_run();
      tick();
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd, bus.o_running} !== {WA, 10'd1, 1'b1}) begin
         n_err++;
         $display("FAIL program_kept: got %h/%0d run=%b want %h/1/1",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, bus.o_running, WA);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      load(10'd1023, WX);
      load(10'd0, WY);
      start_run();
      // Redirect together with a stall: redirect must win
      bus.i_branch_taken  = 1'b1;
      bus.i_branch_target = 10'd1023;
      bus.i_stall         = 1'b1;
      tick();
      bus.i_branch_taken  = 1'b0;
      bus.i_stall         = 1'b0;
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd} !== {NOP, 10'd1023}) begin
         n_err++;
         $display("FAIL wrap_bubble: got %h/%0d want %h/1023",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, NOP);
      end
      tick();
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd} !== {WX, 10'd0}) begin
         n_err++;
         $display("FAIL wrap_last: got %h/%0d want %h/0",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, WX);
      end
      tick();
      n_cmp++;
      if ({bus.o_instruction_ltchd, bus.o_pc_ltchd} !== {WY, 10'd1}) begin
         n_err++;
         $display("FAIL wrap_first: got %h/%0d want %h/1",
                  bus.o_instruction_ltchd, bus.o_pc_ltchd, WY);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n               = 1'b0;
      bus.i_start         = 1'b0;
      bus.i_stall         = 1'b0;
      bus.i_branch_taken  = 1'b0;
      bus.i_branch_target = '0;
      bus.i_inst_wr_enb   = 1'b0;
      bus.i_inst_wr_addr  = '0;
      bus.i_inst_wr_data  = '0;
      #12;
      rst_n = 1'b1;
      test_reset();
      test_load_run();
      test_stall();
      test_branch();
      test_halt();
      test_async_reset();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

First pipeline stage of the MIPS-style core. Holds the program counter, the instruction memory and the IF/ID pipeline latch. Feeds `instruction_decode_unit` with `i_pipeline_ifu_instruction` and `i_pc_stage_0`. A small run-control FSM loads the program while idle, fetches while running and freezes on a HALT instruction.

## Interface
Parameters:
- `NB_DATA`, 32: instruction width.
- `NB_PC`, 10: program counter width; memory depth is 2**NB_PC words.
- `HALT_INSTR`, 32'hFFFF_FFFF: encoding that halts fetch.
- `NOP_INSTR`, 32'h0000_0000: bubble encoding.

Ports:
- `i_clock`  in  1  single clock; all state updates on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  IDLE→RUN request.
- `i_stall`  in  1  hazard stall from decode; holds PC and latch.
- `i_branch_taken`  in  1  redirect request from a later stage.
- `i_branch_target`  in  NB_PC  redirect address.
- `i_inst_wr_enb`  in  1  program-load write strobe.
- `i_inst_wr_addr`  in  NB_PC  program-load word address.
- `i_inst_wr_data`  in  NB_DATA  program-load word.
- `o_instruction_ltchd`  out  NB_DATA  IF/ID instruction; drives decode `i_pipeline_ifu_instruction`.
- `o_pc_ltchd`  out  NB_PC  IF/ID PC+1 of the latched instruction; drives decode `i_pc_stage_0`.
- `o_running`  out  1  FSM is in RUN.
- `o_halted`  out  1  FSM is in HALTED.

## Operation
- FSM states and transitions:
  - IDLE → RUN when `i_start`=1.
  - RUN → HALTED when the word fetched at PC equals HALT_INSTR and that cycle is not overridden (see priority below).
  - HALTED is left only by reset. `i_start` is ignored outside IDLE.
- Instruction memory:
  - Asynchronous read at PC.
  - Synchronous write, accepted only in IDLE. Writes in RUN or HALTED are dropped.
  - Reset does not clear memory contents.
- Per-cycle update in RUN, highest priority first:
  1. `i_branch_taken`: PC←`i_branch_target`; latch instr←NOP_INSTR; latch pc←`i_branch_target`. The same-cycle HALT and stall are ignored.
  2. `i_stall`: PC and both latches hold.
  3. Fetched word == HALT_INSTR: PC holds; latch instr←NOP_INSTR; latch pc holds; next state HALTED.
  4. Otherwise: latch instr←mem[PC]; latch pc←PC+1; PC←PC+1.
- In IDLE and HALTED: PC holds and latch instr is forced to NOP_INSTR every cycle.
- PC arithmetic is modulo 2**NB_PC: PC 2**NB_PC−1 advances to 0, and PC+1 wraps the same way.

## Timing
- Reset values (applied asynchronously): PC=0, state=IDLE, `o_instruction_ltchd`=NOP_INSTR, `o_pc_ltchd`=0, `o_running`=0, `o_halted`=0.
- Fetch latency: the word at PC is presented on `o_instruction_ltchd` one edge after PC holds that value.
- The first fetch happens on the edge after the one that enters RUN. Edge N latches the RUN state; edge N+1 latches mem[0].
- `o_running` and `o_halted` are registered state decodes. `o_halted` rises on the same edge that latches the NOP replacing HALT.
- Branch: the NOP bubble appears on the redirect edge. mem[target] appears on the following edge. Redirect penalty is 1 bubble.
- Stall held for k cycles: outputs are unchanged for exactly k edges, then normal advance resumes.
- A write in IDLE is visible to a read on the next cycle.
- Reset asserted mid-RUN: all outputs take their reset values immediately, without waiting for a clock edge. On release, the FSM sits in IDLE and the loaded program is preserved.

## Structure
- Shared package `ifu_pkg`: NOP_INSTR, HALT_INSTR, FSM state encoding (IDLE=2'd0, RUN=2'd1, HALTED=2'd2).
- Sub-module `instruction_memory`: async read, sync write, 2**NB_PC × NB_DATA.
- Top level holds the FSM, the PC register and the IF/ID latch.

## Test plan
- Load mem[0..3]=A,B,C,D in IDLE, pulse `i_start` → latch shows A,B,C,D with pc 1,2,3,4 on consecutive edges; `o_running`=1.
- With B latched, hold `i_stall` 3 cycles → B/pc=2 held 3 edges, then C/pc=3.
- With A latched and PC=1, raise `i_branch_taken` with target=3 → NOP/pc=3 on that edge, then D/pc=4.
- mem[2]=HALT_INSTR → A, B, NOP, then `o_halted`=1; PC stays 2; a further `i_start` and a write of mem[0] have no effect.
- Load mem[1023]=X and mem[0]=Y, branch to 1023 → X/pc=0, then Y/pc=1 (wrap-around).
- Assert `i_reset_n`=0 mid-RUN, between edges → outputs go to NOP/0/0/0 immediately; after release, pulse `i_start` → the original mem[0] is fetched.
